multiplicador_16x16_sequencial: RTL
===================================

# multiplicador_16x16_sequencial

Multi-cycle 16x16 unsigned multiplier controller. It computes a 32-bit product by time-sharing a single `multiplicador_8x8_recursivo` instance over four partial products and accumulating the shifted results in a 32-bit register. It sits between the ALU operation decoder and the result bus, and trades latency for area against a fully parallel 16x16 array.

## Interface
- Parameters: none. Widths are fixed: 16-bit operands, 32-bit product.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request. Sampled only when the block is accepting (IDLE or DONE).
- `a`  in  16  multiplicand, unsigned. Sampled with `start`.
- `b`  in  16  multiplier, unsigned. Sampled with `start`.
- `busy`  out  1  high while an accepted operation is in progress (MUL state).
- `done`  out  1  one-cycle pulse; `p` is valid in that cycle.
- `p`  out  32  product register; holds the last completed result until the next completion.

## Operation
- Operand registers `ra`, `rb` (16 b), accumulator `acc` (32 b), step counter `step` (2 b), state register.
- States:
  - IDLE: `busy`=0, `done`=0.
  - MUL: `busy`=1, `done`=0.
  - DONE: `busy`=0, `done`=1.
- IDLE or DONE with `start`=1: latch `ra`<=`a`, `rb`<=`b`, `acc`<=0, `step`<=0, go to MUL.
- DONE with `start`=0: go to IDLE.
- MUL, each cycle: the 8x8 unit is fed the operand halves selected by `step`, and `acc`<=`acc` + (partial product << shift).
  - `step`=0: `ra[7:0]*rb[7:0]`, shift 0
  - `step`=1: `ra[15:8]*rb[7:0]`, shift 8
  - `step`=2: `ra[7:0]*rb[15:8]`, shift 8
  - `step`=3: `ra[15:8]*rb[15:8]`, shift 16
- MUL with `step`=3: `p`<=final sum (`acc` + term), go to DONE. Otherwise `step`<=`step`+1.
- Arithmetic: the 16-bit partial product is zero-extended to 32 b before the shift. The 32-bit accumulation never overflows, since every running sum is at most (2^16−1)^2.
- `start` during MUL is ignored. `a` and `b` may change freely after acceptance without affecting the result.
- `p` changes only on the DONE entry edge (or on reset).

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `p`=0, `acc`=0, `step`=0.
- `rst` has priority over every other event.
  - Reset mid-MUL aborts the operation.
  - The result is discarded: `p` goes to 0 and no `done` pulse occurs.
- Latency:
  - `start` is accepted at edge k.
  - `busy`=1 during cycles k+1..k+4.
  - `done`=1 and the new `p` appear after edge k+4, for exactly one cycle.
- Throughput: a `start` held high in the DONE cycle is accepted at edge k+5. `busy` rises again with no IDLE cycle in between, giving one result per 5 cycles.
- A `start` pulse that arrives only while `busy`=1 is lost. The requester must hold `start` until it observes `busy` rising.
- The 8x8 unit is purely combinational and sits within the single-cycle accumulate path. No extra pipeline stage.

## Test plan
- Reset → `busy`=0, `done`=0, `p`=0x00000000. Then `a`=0x1234, `b`=0x5678, `start` held for one cycle → `busy` high for 4 cycles, then `done` for 1 cycle with `p`=0x06260060.
- `a`=0xFFFF, `b`=0xFFFF → `p`=0xFFFE0001. `a`=0x00FF, `b`=0x0100 → `p`=0x0000FF00. `a`=0, `b`=0xBEEF → `p`=0.
- During MUL of 0x0003*0x0005: pulse `start` with `a`=0xFFFF, `b`=0xFFFF, and change `a`/`b` → single `done`, `p`=0x0000000F, no second operation.
- `start` held continuously with 0x0002*0x0003, then 0x0010*0x0010 presented in the DONE cycle → `done` pulses 5 cycles apart, `p`=0x00000006 then 0x00000100.
- After a completed result 0x00000006, start 0xFFFF*0xFFFF and assert `rst` at `step`=2 → `p`=0, `busy`=0, no `done`. Next `start` with 0x0007*0x0009 → `p`=0x0000003F.

Source files
------------

// File: rtl/multiplicador_16x16_sequencial.sv
// Sequential 16x16 unsigned multiplier: one shared 8x8 unit, four partial
// products accumulated over four MUL cycles, result held in p until the next completion.

module multiplicador_8x8_recursivo (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    // 2x2 leaf product; operands zero-extended so the product fits in 4 bits
    function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
        return {2'b00, x} * {2'b00, y};
    endfunction

    function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] ll, lh, hl, hh;
        ll = {4'd0, mul2(x[1:0], y[1:0])};
        lh = {4'd0, mul2(x[1:0], y[3:2])};
        hl = {4'd0, mul2(x[3:2], y[1:0])};
        hh = {4'd0, mul2(x[3:2], y[3:2])};
        return ll + (lh << 2) + (hl << 2) + (hh << 4);
    endfunction

    logic [15:0] ll_s, lh_s, hl_s, hh_s;

    // Top level of the recursion: four 4x4 products, shifted and summed
    always_comb begin
        ll_s = {8'd0, mul4(a_i[3:0], b_i[3:0])};
        lh_s = {8'd0, mul4(a_i[3:0], b_i[7:4])};
        hl_s = {8'd0, mul4(a_i[7:4], b_i[3:0])};
        hh_s = {8'd0, mul4(a_i[7:4], b_i[7:4])};
        p_o  = ll_s + (lh_s << 4) + (hl_s << 4) + (hh_s << 8);
    end

endmodule

module multiplicador_16x16_sequencial (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] ra_q;
    logic [15:0] rb_q;
    logic [31:0] acc_q;
    logic [1:0]  step_q;
    logic [31:0] p_q;
    logic        busy_q;
    logic        done_q;

    logic [7:0]  op_a_s;
    logic [7:0]  op_b_s;
    logic [4:0]  shift_s;
    logic [15:0] pp_s;
    logic [31:0] term_s;
    logic [31:0] acc_d;

    // Operand-half selection and shift amount for the current step
    always_comb begin
        op_a_s  = ra_q[7:0];
        op_b_s  = rb_q[7:0];
        shift_s = 5'd0;
        case (step_q)
            2'd0: begin
                op_a_s  = ra_q[7:0];
                op_b_s  = rb_q[7:0];
                shift_s = 5'd0;
            end
            2'd1: begin
                op_a_s  = ra_q[15:8];
                op_b_s  = rb_q[7:0];
                shift_s = 5'd8;
            end
            2'd2: begin
                op_a_s  = ra_q[7:0];
                op_b_s  = rb_q[15:8];
                shift_s = 5'd8;
            end
            2'd3: begin
                op_a_s  = ra_q[15:8];
                op_b_s  = rb_q[15:8];
                shift_s = 5'd16;
            end
            default: begin
                op_a_s  = 8'd0;
                op_b_s  = 8'd0;
                shift_s = 5'd0;
            end
        endcase
    end

    multiplicador_8x8_recursivo u_mul8 (
        .a_i (op_a_s),
        .b_i (op_b_s),
        .p_o (pp_s)
    );

    // The sum stays within 32 bits: every running total is at most (2^16-1)^2
    always_comb begin
        term_s = {16'd0, pp_s} << shift_s;
        acc_d  = acc_q + term_s;
    end

    // Controller FSM with registered busy/done/p; reset drops any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= 16'd0;
            rb_q    <= 16'd0;
            acc_q   <= 32'd0;
            step_q  <= 2'd0;
            p_q     <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        ra_q    <= a;
                        rb_q    <= b;
                        acc_q   <= 32'd0;
                        step_q  <= 2'd0;
                        state_q <= MUL;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    if (step_q == 2'd3) begin
                        p_q     <= acc_d;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        step_q  <= step_q + 2'd1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule
